// File: rtl/body_scanner_pkg.sv
// body_scanner_pkg: shared sizes and FSM state encoding for the body scanner
package body_scanner_pkg;
   localparam int DEPTH = 26;
   localparam int W     = 11;
   localparam int LW    = 6;
   localparam int IW    = $clog2(DEPTH);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/body_scanner_pos_match.sv
// pos_match: registered XY equality compare, gated by valid
module pos_match
   import body_scanner_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         valid,
   input  logic [W-1:0] ax,
   input  logic [W-1:0] ay,
   input  logic [W-1:0] bx,
   input  logic [W-1:0] by,
   output logic         match
);
   // one-cycle registered match of two positions
   always_ff @(posedge clk or posedge reset)
      if (reset) match <= 1'b0;
      else match <= valid && ax == bx && ay == by;
endmodule

// File: rtl/body_scanner.sv
// body_scanner: sweeps the body store each tick and flags head/food overlap
module body_scanner
   import body_scanner_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [LW-1:0] length,
   input  logic [W-1:0]  head_x,
   input  logic [W-1:0]  head_y,
   input  logic [W-1:0]  food_x,
   input  logic [W-1:0]  food_y,
   input  logic [W-1:0]  seg_x,
   input  logic [W-1:0]  seg_y,
   output logic          obtener,
   output logic          busy,
   output logic          done,
   output logic          hit_body,
   output logic          food_on_body
);
   logic [1:0]    state;
   logic [IW-1:0] rd_idx, cmp_idx;
   logic [LW-1:0] len_q;
   logic [W-1:0]  hx, hy, fx, fy;
   logic          cmp_v, valid, acc_h, acc_f, m_h, m_f;
   assign obtener = state == SCAN;
   assign valid   = cmp_v && (LW'(cmp_idx) < len_q);
   pos_match u_head (.clk(clk), .reset(reset), .valid(valid), .ax(seg_x), .ay(seg_y), .bx(hx), .by(hy), .match(m_h));
   pos_match u_food (.clk(clk), .reset(reset), .valid(valid), .ax(seg_x), .ay(seg_y), .bx(fx), .by(fy), .match(m_f));
   // scan FSM: DEPTH strobes, one drain cycle, then publish the sticky results
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         rd_idx <= '0;
         cmp_idx <= '0;
         cmp_v <= 1'b0;
         len_q <= '0;
         hx <= '0;
         hy <= '0;
         fx <= '0;
         fy <= '0;
         acc_h <= 1'b0;
         acc_f <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         hit_body <= 1'b0;
         food_on_body <= 1'b0;
      end else begin
         done <= 1'b0;
         cmp_v <= obtener;
         cmp_idx <= rd_idx;
         if (state == IDLE && start && !done) begin
            state <= SCAN;
            busy <= 1'b1;
            rd_idx <= '0;
            len_q <= length > LW'(DEPTH) ? LW'(DEPTH) : length;
            hx <= head_x;
            hy <= head_y;
            fx <= food_x;
            fy <= food_y;
            acc_h <= 1'b0;
            acc_f <= 1'b0;
         end else if (state == SCAN || state == DRAIN) begin
            acc_h <= acc_h | m_h;
            acc_f <= acc_f | m_f;
            if (state == DRAIN) state <= DONE;
            else if (rd_idx == IW'(DEPTH - 1)) begin
               state <= DRAIN;
               rd_idx <= '0;
            end else rd_idx <= rd_idx + 1'b1;
         end else if (state == DONE) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            hit_body <= acc_h | m_h;
            food_on_body <= acc_f | m_f;
         end
      end
endmodule

// File: tb/tb_body_scanner.sv
// tb_body_scanner: directed checks of body_scanner against a simple store model
module tb_body_scanner;
   logic        clk = 0, reset = 1, start = 0;
   logic [5:0]  length = 0;
   logic [10:0] head_x = 0, head_y = 0, food_x = 0, food_y = 0, seg_x, seg_y;
   logic        obtener, busy, done, hit_body, food_on_body;
   logic [10:0] mx [26];
   logic [10:0] my [26];
   int          ptr;
   int          tests = 0, fails = 0;

   body_scanner dut (.clk(clk), .reset(reset), .start(start), .length(length),
      .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
      .seg_x(seg_x), .seg_y(seg_y), .obtener(obtener), .busy(busy), .done(done),
      .hit_body(hit_body), .food_on_body(food_on_body));

   always #5 clk = ~clk;

   // store model: one-cycle read latency, pointer wraps at 25
   always @(posedge clk or posedge reset)
      if (reset) begin
         ptr <= 0;
         seg_x <= 0;
         seg_y <= 0;
      end else if (obtener) begin
         seg_x <= mx[ptr];
         seg_y <= my[ptr];
         ptr <= ptr == 25 ? 0 : ptr + 1;
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic run(input logic [5:0] len, input logic [10:0] hx, hy, fx, fy,
                      input int repulse, input bit dstart);
      int n, ob;
      chk("store_aligned", ptr, 0);
      length = len; head_x = hx; head_y = hy; food_x = fx; food_y = fy;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("busy_after_start", busy, 1);
      n = 0;
      ob = obtener ? 1 : 0;
      while (!done && n <= 60) begin
         start = (n == repulse);
         @(posedge clk); #1;
         n++;
         if (obtener) ob++;
      end
      start = 0;
      chk("done_latency", n, 28);
      chk("strobe_count", ob, 26);
      chk("busy_at_done", busy, 0);
      start = dstart;
      @(posedge clk); #1;
      start = 0;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 26; i++) begin
         mx[i] = 11'(100 + i);
         my[i] = 11'd200;
      end
      mx[0] = 10; my[0] = 10;
      mx[1] = 11; my[1] = 10;
      mx[2] = 12; my[2] = 10;
      #1;
      chk("rst_obtener", obtener, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hit", hit_body, 0);
      chk("rst_food", food_on_body, 0);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(posedge clk); #1;

      run(3, 12, 10, 0, 0, -1, 0);
      chk("head_on_tail_hit", hit_body, 1);
      chk("head_on_tail_food", food_on_body, 0);

      mx[5] = 20; my[5] = 20;
      run(3, 20, 20, 0, 0, -1, 0);
      chk("beyond_len_hit", hit_body, 0);
      chk("beyond_len_food", food_on_body, 0);

      run(3, 50, 50, 11, 10, -1, 0);
      chk("food_hit", hit_body, 0);
      chk("food_food", food_on_body, 1);

      run(3, 12, 10, 11, 10, 5, 1);
      chk("repulse_hit", hit_body, 1);
      chk("repulse_food", food_on_body, 1);
      run(3, 12, 10, 11, 10, -1, 0);
      chk("b2b_hit", hit_body, 1);
      chk("b2b_food", food_on_body, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_hit", hit_body, 1);
      chk("hold_food", food_on_body, 1);

      run(0, 10, 10, 10, 10, -1, 0);
      chk("len0_hit", hit_body, 0);
      chk("len0_food", food_on_body, 0);

      run(25, 125, 200, 10, 10, -1, 0);
      chk("len25_hit", hit_body, 0);
      chk("len25_food", food_on_body, 1);

      run(40, 125, 200, 11, 10, -1, 0);
      chk("clamp_hit", hit_body, 1);
      chk("clamp_food", food_on_body, 1);

      length = 3; head_x = 12; head_y = 10; food_x = 11; food_y = 10;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (10) @(posedge clk);
      #2 reset = 1;
      #1;
      chk("abort_obtener", obtener, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hit", hit_body, 0);
      chk("abort_food", food_on_body, 0);
      @(posedge clk); #1 reset = 0;
      @(posedge clk); #1;
      run(3, 12, 10, 0, 0, -1, 0);
      chk("post_reset_hit", hit_body, 1);
      chk("post_reset_food", food_on_body, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
